la_sample_fifo: RTL and testbench

Capture front end of the logic analyzer. Samples the 8-bit `logic_input` bus at a programmable rate and buffers the samples in a small FIFO. It presents them with a valid/ready handshake to the FTDI fast-serial frame transmitter, which wraps each byte in a start/destination frame on `FSDI`. The FIFO absorbs the transmitter's `FSCTS` stalls. Overflow is recorded instead of being silently lost.

---
 rtl/la_sample_fifo.sv | 123 ++++++++++++
 tb/tb_la_sample_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/la_sample_fifo.sv
// Logic-analyzer capture front end: divided sample strobe feeding a FWFT FIFO with sticky overflow.
// Optional macro LA_INPUT_SYNC_EN adds a 2-flop synchronizer ahead of the sampler.
`timescale 1ns/1ps
module la_sample_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      div,
  input  logic [7:0]            logic_input,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]    CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [DEPTH_LOG2:0] r_level;
  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_overflow;
  logic [7:0]          r_drop_count;

  logic                w_strobe;
  logic                w_full;
  logic                w_empty;
  logic                w_wr;
  logic                w_rd;
  logic [7:0]          w_sample;

`ifdef LA_INPUT_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= logic_input;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = logic_input;
`endif

  // >= rather than == so that lowering div below the running count strobes at once.
  assign w_strobe = enable && (r_div_cnt >= div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!enable || w_strobe) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_ONE;
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  // Fullness is judged before this cycle's read, so a read never makes room for a same-cycle write.
  assign w_wr    = w_strobe && !w_full;
  assign w_rd    = !w_empty && out_ready;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + PTR_ONE;
        2'b01:   r_level <= r_level - PTR_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_strobe && w_full) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign out_data   = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign out_valid  = !w_empty;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_la_sample_fifo.sv
// Directed bench for la_sample_fifo with a queue scoreboard of sampled bytes.
`timescale 1ns/1ps
module tb_la_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] div;
  logic [7:0]  logic_input;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_err = 0;
  int n_checks = 0;

  logic [7:0] m_q[$];
  int         m_cnt;
  bit         m_ovf;
  int         m_drop;
  logic [7:0] m_s1, m_s2;

  la_sample_fifo #(.DEPTH_LOG2(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .div(div), .logic_input(logic_input),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_drop = 0;
    m_s1 = '0;
    m_s2 = '0;
  endtask

  // Advance one clock: update the reference model from pre-edge inputs, then compare after the edge.
  task automatic cyc();
    bit strb, full, rd;
    logic [7:0] smp;
`ifdef LA_INPUT_SYNC_EN
    smp = m_s2;
`else
    smp = logic_input;
`endif
    strb = enable && (m_cnt >= int'(div));
    full = (m_q.size() == 16);
    rd   = (m_q.size() != 0) && out_ready;
    if (rd) void'(m_q.pop_front());
    if (strb) begin
      if (!full) m_q.push_back(smp);
      else begin
        m_ovf = 1'b1;
        if (m_drop != 255) m_drop++;
      end
    end
    if (!enable || strb) m_cnt = 0;
    else m_cnt++;
    m_s2 = m_s1;
    m_s1 = logic_input;
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    check("level", {27'd0, level}, m_q.size());
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("drop_count", {24'd0, drop_count}, m_drop);
    if (m_q.size() != 0) check("out_data", {24'd0, out_data}, {24'd0, m_q[0]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    int n;
    bit v[16];

    rst = 1'b1; enable = 1'b0; div = '0; logic_input = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_level", {27'd0, level}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_drop", {24'd0, drop_count}, 0);
    rst = 1'b0;

    // Ramp at full rate with an always-ready consumer
    div = 16'd0; out_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic_input = 8'(i);
      cyc();
      check("ramp_level_le1", {31'd0, level <= 5'd1}, 1);
    end
    enable = 1'b0;
    repeat (3) cyc();
    check("ramp_no_overflow", {31'd0, overflow}, 0);

    // div=3 constant pattern: first strobe on edge 3, then every 4 edges
    logic_input = 8'hA5;
    repeat (3) cyc();
    div = 16'd3; enable = 1'b1; nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      v[i] = out_valid;
      if (out_valid) nvalid++;
    end
    check("div3_no_early", {31'd0, v[2]}, 0);
    check("div3_first", {31'd0, v[3]}, 1);
    check("div3_pulses", nvalid, 4);
    enable = 1'b0;
    repeat (3) cyc();

    // Stalled consumer: 20 strobes into a 16-deep FIFO
    div = 16'd0; out_ready = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      logic_input = 8'(i);
      cyc();
      if (i == 16) begin
        check("fill_level16", {27'd0, level}, 16);
        check("fill_no_ovf_yet", {31'd0, overflow}, 0);
      end
      if (i == 17) check("fill_ovf_on17", {31'd0, overflow}, 1);
    end
    enable = 1'b0;
    check("fill_drop4", {24'd0, drop_count}, 4);
    out_ready = 1'b1; n = 0;
    while (out_valid && n < 40) begin
      cyc();
      n++;
    end
    check("drain_count", n, 16);
    check("drain_empty", {31'd0, out_valid}, 0);

    // Full FIFO with a strobe and a transfer on the same edge
    out_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic_input = 8'(8'h40 + i);
      cyc();
    end
    check("full_level", {27'd0, level}, 16);
    check("full_drop_before", {24'd0, drop_count}, 4);
    logic_input = 8'hEE; out_ready = 1'b1;
    cyc();
    check("fullrd_level15", {27'd0, level}, 15);
    check("fullrd_drop5", {24'd0, drop_count}, 5);

    // Saturation of the drop counter
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic_input = 8'($urandom_range(0, 255));
      cyc();
    end
    check("sat_drop255", {24'd0, drop_count}, 255);
    check("sat_overflow", {31'd0, overflow}, 1);
    cyc();
    check("sat_hold", {24'd0, drop_count}, 255);

    // Asynchronous reset with 10 entries buffered
    enable = 1'b0; out_ready = 1'b1; n = 0;
    while (out_valid && n < 40) begin
      cyc();
      n++;
    end
    check("pre_rst_empty", {31'd0, out_valid}, 0);
    out_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic_input = 8'(8'h10 + i);
      cyc();
    end
    check("pre_rst_level10", {27'd0, level}, 10);
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 0);
    check("arst_level", {27'd0, level}, 0);
    check("arst_overflow", {31'd0, overflow}, 0);
    check("arst_drop", {24'd0, drop_count}, 0);
    model_reset();
    #1;
    rst = 1'b0;

    // Capture restarts cleanly after reset
    out_ready = 1'b1; div = 16'd1;
    for (int i = 0; i < 24; i++) begin
      logic_input = 8'(8'hC0 + i);
      cyc();
    end
    check("post_rst_no_ovf", {31'd0, overflow}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
